// File: rtl/bin_fcl_engine.sv
// Binary fully-connected-layer engine: N_PE XNOR-popcount lanes accumulate one
// output neuron each over a variable-length stream of binary input beats, then
// round, shift and saturate the result into a valid/ready output stage.
module bin_fcl_engine #(
  parameter int IN_BITS   = 64,
  parameter int N_PE      = 8,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_BITS-1:0]            in_x,
  input  logic [N_PE*IN_BITS-1:0]       in_w,
  input  logic                          in_last,
  input  logic [$clog2(ACC_WIDTH)-1:0]  shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_PE*OUT_WIDTH-1:0]     out_data,
  output logic [15:0]                   beat_cnt
);

  localparam int PW  = $clog2(IN_BITS) + 2;
  localparam int SW  = $clog2(ACC_WIDTH);
  localparam int AW1 = ACC_WIDTH + 1;
  localparam int TW  = ACC_WIDTH - OUT_WIDTH + 2;

  typedef enum logic {S_ACCUM, S_HOLD} state_t;

  state_t state_q, state_d;
  logic   first_q;
  logic   accept;

  logic signed [ACC_WIDTH-1:0] acc_q [N_PE];
  logic signed [ACC_WIDTH-1:0] acc_d [N_PE];
  logic signed [ACC_WIDTH-1:0] ext_w [N_PE];
  logic signed [OUT_WIDTH-1:0] res_d [N_PE];
  logic [N_PE*OUT_WIDTH-1:0]   out_data_q;
  logic [15:0]                 beat_cnt_q, beat_cnt_d;

  // 2*popcount(xnor) - IN_BITS; the unsigned wrap of the subtraction yields the signed value
  function automatic logic signed [PW-1:0] partial_f(input logic [IN_BITS-1:0] x,
                                                     input logic [IN_BITS-1:0] w);
    logic [PW-1:0] pc;
    pc = '0;
    for (int i = 0; i < IN_BITS; i++) pc = pc + {{(PW-1){1'b0}}, ~(x[i] ^ w[i])};
    return $signed((pc << 1) - PW'(IN_BITS));
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sext_f(input logic signed [PW-1:0] v);
    return {{(ACC_WIDTH-PW){v[PW-1]}}, v};
  endfunction

  // Clamp a one-bit-wider sum back into the accumulator range
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc_f(input logic signed [ACC_WIDTH:0] v);
    if (v[ACC_WIDTH] != v[ACC_WIDTH-1])
      return v[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return v[ACC_WIDTH-1:0];
  endfunction

  // Round-half-up arithmetic shift; the guard bit keeps acc+bias from wrapping at +max
  function automatic logic signed [ACC_WIDTH:0] round_f(input logic signed [ACC_WIDTH-1:0] a,
                                                        input logic [SW-1:0] sh);
    logic signed [ACC_WIDTH:0] bias;
    logic signed [ACC_WIDTH:0] sum;
    bias = (sh != '0) ? (AW1'(1) << (sh - 1'b1)) : '0;
    sum  = {a[ACC_WIDTH-1], a} + bias;
    return sum >>> sh;
  endfunction

  // Clamp the rounded value into the signed output range
  function automatic logic signed [OUT_WIDTH-1:0] sat_out_f(input logic signed [ACC_WIDTH:0] r);
    logic [TW-1:0] top;
    top = r[ACC_WIDTH:OUT_WIDTH-1];
    if ((&top) || !(|top)) return r[OUT_WIDTH-1:0];
    return r[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  endfunction

  assign accept   = in_valid && in_ready;
  assign out_data = out_data_q;
  assign beat_cnt = beat_cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_ACCUM;
    else      state_q <= state_d;
  end

  // Next state: last accepted beat enters HOLD, consumer handshake returns to ACCUM
  always_comb begin
    state_d = state_q;
    if (state_q == S_ACCUM) begin
      if (accept && in_last) state_d = S_HOLD;
    end else if (out_ready) begin
      state_d = S_ACCUM;
    end
  end

  // Handshake outputs; in_ready is held low while reset is asserted
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (state_q == S_ACCUM) in_ready  = rst;
    else                    out_valid = 1'b1;
  end

  // Per-lane partial, saturating accumulate and output rounding for the current beat
  always_comb begin
    for (int p = 0; p < N_PE; p++) begin
      ext_w[p] = sext_f(partial_f(in_x, in_w[p*IN_BITS +: IN_BITS]));
      if (first_q) acc_d[p] = ext_w[p];
      else         acc_d[p] = sat_acc_f({acc_q[p][ACC_WIDTH-1], acc_q[p]} +
                                        {ext_w[p][ACC_WIDTH-1], ext_w[p]});
      res_d[p] = sat_out_f(round_f(acc_d[p], shift));
    end
    if (first_q)                     beat_cnt_d = 16'd1;
    else if (beat_cnt_q == 16'hFFFF) beat_cnt_d = beat_cnt_q;
    else                             beat_cnt_d = beat_cnt_q + 16'd1;
  end

  // Accumulator, beat counter and output registers; updated only on accepted beats
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < N_PE; p++) acc_q[p] <= '0;
      out_data_q <= '0;
      beat_cnt_q <= '0;
      first_q    <= 1'b1;
    end else if (accept) begin
      for (int p = 0; p < N_PE; p++) acc_q[p] <= acc_d[p];
      beat_cnt_q <= beat_cnt_d;
      first_q    <= in_last;
      if (in_last)
        for (int p = 0; p < N_PE; p++) out_data_q[p*OUT_WIDTH +: OUT_WIDTH] <= res_d[p];
    end
  end

endmodule

// File: tb/tb_bin_fcl_engine.sv
// Directed testbench for bin_fcl_engine with default parameters.
module tb_bin_fcl_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_x;
  logic [511:0] in_w;
  logic         in_last;
  logic [3:0]   shift;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [15:0]  beat_cnt;

  int vecs = 0;
  int errs = 0;

  bin_fcl_engine dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_last(in_last), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] x, input logic [511:0] w,
                      input logic last, input logic [3:0] sh);
    in_valid = 1'b1; in_x = x; in_w = w; in_last = last; shift = sh;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovld_after"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_irdy_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  function automatic logic [63:0] ones_n(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  logic [63:0]  x_a;
  logic [63:0]  held;
  logic [511:0] w_a;
  logic [511:0] w_pos, w_neg, w_half, w_l0;
  int           pcs [8];

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0; in_last = 1'b0;
    shift = '0; out_ready = 1'b0;
    w_pos  = '1;
    w_neg  = '0;
    w_half = {{256{1'b0}}, {256{1'b1}}};
    w_l0   = {{448{1'b0}}, {64{1'b1}}};

    // reset values
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
    rst = 1'b1; #1;
    chk("rst_rel_in_ready", {63'd0, in_ready}, 64'd1);

    // single beat, all +1 agreement -> 64 per lane
    x_a = 64'hA5C3_0F96_1234_FEDC;
    beat(x_a, {8{x_a}}, 1'b1, 4'd0);
    chk("one_ovld", {63'd0, out_valid}, 64'd1);
    chk("one_irdy", {63'd0, in_ready}, 64'd0);
    chk("one_data", out_data, {8{8'h40}});
    chk("one_cnt", {48'd0, beat_cnt}, 64'd1);
    release_out("one");

    // two beats: lane0 -64 then +64 -> 0; other lanes 128 -> saturate 127
    beat(x_a, {{7{x_a}}, ~x_a}, 1'b0, 4'd0);
    chk("two_mid_ovld", {63'd0, out_valid}, 64'd0);
    chk("two_mid_cnt", {48'd0, beat_cnt}, 64'd1);
    beat(x_a, {8{x_a}}, 1'b1, 4'd0);
    chk("two_data", out_data, 64'h7F7F7F7F_7F7F7F00);
    chk("two_cnt", {48'd0, beat_cnt}, 64'd2);
    release_out("two");

    // rounding, shift=2: partials 6,-6,2,-2,10,-10,0,64
    pcs = '{35, 29, 33, 31, 37, 27, 32, 64};
    for (int p = 0; p < 8; p++) w_a[p*64 +: 64] = ones_n(pcs[p]);
    beat('1, w_a, 1'b1, 4'd2);
    chk("rnd_data", out_data, 64'h1000FE03_0001FF02);

    // backpressure with ignored junk input beats
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_last = 1'b1; in_x = 64'h0; in_w = '0; shift = 4'd3;
      @(posedge clk); #1;
      chk("bp_ovld", {63'd0, out_valid}, 64'd1);
      chk("bp_data", out_data, held);
      chk("bp_irdy", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    release_out("bp");
    beat('1, w_pos, 1'b1, 4'd0);
    chk("bp_next_data", out_data, {8{8'h40}});
    chk("bp_next_cnt", {48'd0, beat_cnt}, 64'd1);
    release_out("bp_next");

    // saturation: 600 beats +64 (lanes 0-3) / -64 (lanes 4-7), shift 0
    for (int i = 0; i < 599; i++) beat('1, w_half, 1'b0, 4'd0);
    beat('1, w_half, 1'b1, 4'd0);
    chk("sat_data", out_data, 64'h80808080_7F7F7F7F);
    chk("sat_cnt", {48'd0, beat_cnt}, 64'd600);
    release_out("sat");

    // sticky saturation: lane0 clamps at 32767 then -64 -> 32703, shift 9 -> 64; others -64
    for (int i = 0; i < 600; i++) beat('1, w_l0, 1'b0, 4'd0);
    beat('1, w_neg, 1'b1, 4'd9);
    chk("sticky_data", out_data, 64'hC0C0C0C0_C0C0C040);
    chk("sticky_cnt", {48'd0, beat_cnt}, 64'd601);
    release_out("sticky");

    // guard bit: 32767 with shift 15 -> 1, -32768 -> -1
    for (int i = 0; i < 599; i++) beat('1, w_half, 1'b0, 4'd0);
    beat('1, w_half, 1'b1, 4'd15);
    chk("guard_data", out_data, 64'hFFFFFFFF_01010101);
    release_out("guard");

    // reset mid-vector discards partial state
    for (int i = 0; i < 3; i++) beat('1, w_pos, 1'b0, 4'd0);
    chk("mid_cnt", {48'd0, beat_cnt}, 64'd3);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_irdy", {63'd0, in_ready}, 64'd0);
    chk("mid_rst_ovld", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_cnt", {48'd0, beat_cnt}, 64'd0);
    rst = 1'b1; #1;
    beat('1, w_pos, 1'b1, 4'd0);
    chk("post_rst_ovld", {63'd0, out_valid}, 64'd1);
    chk("post_rst_data", out_data, {8{8'h40}});
    chk("post_rst_cnt", {48'd0, beat_cnt}, 64'd1);
    release_out("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bin_fcl_engine.md
# bin_fcl_engine

Parametrised binary fully-connected-layer engine: `N_PE` parallel XNOR-popcount lanes accumulate one output neuron each over a variable-length stream of `IN_BITS`-wide binary input beats. On the last beat of a vector, each lane applies a rounding arithmetic right shift, saturates to `OUT_WIDTH` and presents the result through a valid/ready output stage. It replaces the fixed-width, free-running FC processing array. Upstream, the activation/weight fetch unit drives it; downstream, the batch-norm/sign stage consumes it.

## Interface
- `IN_BITS`, 64: binary activations per input beat (power of two, ≥ 8).
- `N_PE`, 8: parallel lanes (output neurons per pass).
- `ACC_WIDTH`, 16: signed accumulator width per lane.
- `OUT_WIDTH`, 8: signed output width per lane.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  engine can accept a beat.
- `in_x`  in  `IN_BITS`  binary activations; 1 = +1, 0 = −1.
- `in_w`  in  `N_PE*IN_BITS`  weights; lane p uses bits [p*IN_BITS +: IN_BITS], same encoding.
- `in_last`  in  1  marks the final beat of the vector.
- `shift`  in  `$clog2(ACC_WIDTH)`  output right-shift; sampled with the last beat.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  `N_PE*OUT_WIDTH`  lane p at [p*OUT_WIDTH +: OUT_WIDTH], signed.
- `beat_cnt`  out  16  beats accepted in the current or last completed vector; saturates at 0xFFFF.

## Operation
- FSM states: ACCUM and HOLD. Reset enters ACCUM with the `first` flag set.
- ACCUM: `in_ready`=1. A beat is accepted when `in_valid && in_ready`.
- Per lane, per accepted beat:
  - partial = 2·popcount(~(in_x ^ w_p)) − IN_BITS.
  - partial is signed, `$clog2(IN_BITS)+2` bits, range ±IN_BITS.
- Accumulate rules:
  - If `first`: acc ← partial, and `beat_cnt` ← 1.
  - Otherwise: acc ← sat(acc + partial), clamped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1], and `beat_cnt` increments.
  - `first` clears after any accepted beat without `in_last`.
- Accepted beat with `in_last`=1:
  - Fold the beat into acc as above, giving acc'.
  - Compute r = (acc' + (shift>0 ? 1<<(shift−1) : 0)) >>> shift. The add is done with 1 guard bit.
  - Register out_data_p = sat_OUT(r), clamped to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - Enter HOLD and set `first`.
- HOLD:
  - `in_ready`=0; `out_valid`=1.
  - `out_data` and `beat_cnt` are stable.
  - On `out_ready`=1: next state ACCUM, `out_valid`→0.
- A single-beat vector (`in_last` on a `first` beat) is legal; the result derives from that beat's partial only.
- `in_x`, `in_w` and `in_last` are ignored when not accepted.
- `shift` is ignored except on the accepted last beat.

## Timing
- Reset values:
  - `in_ready`=0 during reset, then 1 from the first cycle after rst deasserts.
  - `out_valid`=0, `out_data`=0, `beat_cnt`=0.
  - Accumulators 0; state ACCUM; `first`=1.
- Throughput: one beat per clock in ACCUM.
- Latency: last beat accepted on edge N → `out_valid`=1 and `out_data` valid after edge N.
- `in_ready` is low in the cycle after edge N. It returns high in the cycle after the edge on which `out_valid && out_ready`.
- Minimum vector-to-vector gap is therefore 1 idle input cycle per vector.
- `out_ready` is don't-care while `out_valid`=0. `out_data` must not change while `out_valid && !out_ready`.
- Reset mid-vector or in HOLD: partial state is discarded with no output, and all reset values apply on the next edge.
- Saturation is sticky within a vector. Further adds operate on the clamped value; there is no wrap-around.

## Test plan
- Defaults. One beat, `in_x`=all 1, all `in_w`=all 1, `in_last`=1, `shift`=0 → next cycle `out_valid`=1, every lane 64, `beat_cnt`=1.
- Two beats: beat 1 with lane0 w=~x (−64), beat 2 with lane0 w=x (+64), `shift`=0 → lane0 = 0, `beat_cnt`=2.
- Saturation: 600 beats of +64 (sum 38400), `shift`=0 → acc clamps at 32767, out 127. The same stream with partial −64 → out −128.
- Rounding: construct acc=5, `shift`=1 → 3. Construct acc=−3, `shift`=1 → −1. Construct acc=6, `shift`=2 → 2.
- Backpressure: hold `out_ready`=0 for 5 cycles → `out_valid` and `out_data` stable and `in_ready`=0 throughout. Assert `out_ready` → `in_ready`=1 in the next cycle, and the next vector starts fresh (`first` behaviour).
- Reset after 3 beats, then a 1-beat vector of +64 → output 64 with no residue, `beat_cnt`=1.
